// File: rtl/dot_prod_ctrl_if.sv
// Handshake/bus bundle between a dot-product requester and dot_prod_ctrl.
// DOT_PROD_CTRL_ABORT_EN adds the abort/aborted pair.
interface dot_prod_ctrl_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] len;
  logic         rd_en;
  logic [N-1:0] addr;
  logic         acc_clr;
  logic         acc_en;
  logic         busy;
  logic         done;
`ifdef DOT_PROD_CTRL_ABORT_EN
  logic         abort;
  logic         aborted;

  modport master (output start, len, abort,
                  input  rd_en, addr, acc_clr, acc_en, busy, done, aborted);
  modport slave  (input  start, len, abort,
                  output rd_en, addr, acc_clr, acc_en, busy, done, aborted);
`else
  modport master (output start, len,
                  input  rd_en, addr, acc_clr, acc_en, busy, done);
  modport slave  (input  start, len,
                  output rd_en, addr, acc_clr, acc_en, busy, done);
`endif
endinterface

// File: rtl/dot_prod_ctrl.sv
// Dot-product sequencer: clears the accumulator, streams len operand reads, then
// waits out the product pipeline before pulsing done. DOT_PROD_CTRL_ABORT_EN adds abort.
module dot_prod_ctrl #(
  parameter int N        = 4,
  parameter int PIPE_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  dot_prod_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t               state, state_nxt;
  logic [N-1:0]         len_q;
  logic [N-1:0]         cnt, cnt_nxt;
  logic [PIPE_LAT:1]    vld_pipe, vld_nxt;
  logic                 rd_en;
  logic                 abort_req;

`ifdef DOT_PROD_CTRL_ABORT_EN
  logic aborted_q;
  assign abort_req   = bus.abort && (state != IDLE);
  assign bus.aborted = aborted_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= abort_req;
`else
  assign abort_req = 1'b0;
`endif

  assign rd_en = (state == RUN);

  // Next contents of the valid shift register; stage 1 takes this cycle's read.
  always_comb begin
    vld_nxt    = '0;
    vld_nxt[1] = rd_en;
    for (int i = 2; i <= PIPE_LAT; i++) vld_nxt[i] = vld_pipe[i-1];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (bus.start) state_nxt = CLR;
      CLR:   state_nxt = (len_q != '0) ? RUN : DONE;
      RUN: begin
        if (cnt == len_q - ONE) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + ONE;
        end
      end
      // Leave once the last product has left the pipe on this edge.
      DRAIN: if (vld_nxt == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_req) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      vld_pipe <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      vld_pipe <= abort_req ? '0 : vld_nxt;
      if (state == IDLE && bus.start) len_q <= bus.len;
    end
  end

  assign bus.rd_en   = rd_en;
  assign bus.addr    = cnt;
  assign bus.acc_clr = (state == CLR);
  assign bus.acc_en  = vld_pipe[PIPE_LAT];
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_dot_prod_ctrl.sv
// Self-checking bench for dot_prod_ctrl: per-cycle outputs are compared against a
// timeline model derived from the operation's cycle offsets relative to the accepting edge.
module tb_dot_prod_ctrl;
  localparam int N  = 4;
  localparam int PL = 2;

  typedef struct packed {
    logic         rd_en;
    logic [N-1:0] addr;
    logic         acc_clr;
    logic         acc_en;
    logic         busy;
    logic         done;
  } obs_t;

  logic clk;
  logic rst;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  dot_prod_ctrl_if #(.N(N)) bus ();

  dot_prod_ctrl #(.N(N), .PIPE_LAT(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs k cycles after the edge that accepted start with length l.
  function automatic obs_t model(int k, int l);
    obs_t e;
    int   dk;
    e  = '0;
    dk = (l == 0) ? 1 : l + PL + 1;
    e.busy    = (k >= 0 && k <= dk);
    e.acc_clr = (k == 0);
    e.done    = (k == dk);
    if (l > 0 && k >= 1 && k <= l) begin
      e.rd_en = 1'b1;
      e.addr  = N'(k - 1);
    end
    e.acc_en  = (l > 0 && k >= 1 + PL && k <= l + PL);
    return e;
  endfunction

  function automatic int done_k(int l);
    return (l == 0) ? 1 : l + PL + 1;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.rd_en   = bus.rd_en;
    o.addr    = bus.addr;
    o.acc_clr = bus.acc_clr;
    o.acc_en  = bus.acc_en;
    o.busy    = bus.busy;
    o.done    = bus.done;
    return o;
  endfunction

  task automatic test_reset();
    obs_t o;
    #3;
    o = sample();
    cmp_cnt++;
    if (o !== obs_t'('0)) begin
      err_cnt++;
      $display("FAIL reset_outputs got=%h exp=%h", o, obs_t'('0));
    end
    @(negedge clk);
    o = sample();
    cmp_cnt++;
    if (o !== obs_t'('0)) begin
      err_cnt++;
      $display("FAIL reset_hold got=%h exp=%h", o, obs_t'('0));
    end
    rst = 1'b0;
    @(negedge clk);
    o = sample();
    cmp_cnt++;
    if (o !== obs_t'('0)) begin
      err_cnt++;
      $display("FAIL idle_after_reset got=%h exp=%h", o, obs_t'('0));
    end
  endtask

  // Directed lengths (typical, zero, maximum, one) followed by random ones.
  task automatic test_lengths();
    int   lens[$];
    obs_t o, e;
    lens = '{3, 0, 15, 1};
    for (int r = 0; r < 6; r++) lens.push_back(int'($urandom_range(15)));
    foreach (lens[i]) begin
      bus.len   = N'(lens[i]);
      bus.start = 1'b1;
      for (int k = 0; k <= done_k(lens[i]) + 1; k++) begin
        @(negedge clk);
        o = sample();
        e = model(k, lens[i]);
        cmp_cnt++;
        if (o !== e) begin
          err_cnt++;
          $display("FAIL length_op l=%0d k=%0d got=%h exp=%h", lens[i], k, o, e);
        end
        if (k == 0) bus.start = 1'b0;
        bus.len = N'($urandom_range(15));
      end
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    bus.len   = N'(5);
    bus.start = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      o = sample();
      e = model(k, 5);
      cmp_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL async_pre k=%0d got=%h exp=%h", k, o, e);
      end
      if (k == 0) bus.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    o = sample();
    cmp_cnt++;
    if (o !== obs_t'('0)) begin
      err_cnt++;
      $display("FAIL async_rst_immediate got=%h exp=%h", o, obs_t'('0));
    end
    @(negedge clk);
    o = sample();
    cmp_cnt++;
    if (o !== obs_t'('0)) begin
      err_cnt++;
      $display("FAIL async_rst_held got=%h exp=%h", o, obs_t'('0));
    end
    rst       = 1'b0;
    bus.len   = N'(2);
    bus.start = 1'b1;
    for (int k = 0; k <= done_k(2) + 1; k++) begin
      @(negedge clk);
      o = sample();
      e = model(k, 2);
      cmp_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL async_post k=%0d got=%h exp=%h", k, o, e);
      end
      if (k == 0) bus.start = 1'b0;
    end
  endtask

  // start held high throughout; len churns while busy and is set just before acceptance.
  task automatic test_back_to_back();
    obs_t o, e;
    int   l;
    bus.start = 1'b1;
    for (int op = 0; op < 4; op++) begin
      l       = int'($urandom_range(15));
      bus.len = N'(l);
      for (int k = 0; k <= done_k(l) + 1; k++) begin
        @(negedge clk);
        o = sample();
        e = model(k, l);
        cmp_cnt++;
        if (o !== e) begin
          err_cnt++;
          $display("FAIL back_to_back op=%0d l=%0d k=%0d got=%h exp=%h", op, l, k, o, e);
        end
        if (k <= done_k(l)) bus.len = N'($urandom_range(15));
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

`ifdef DOT_PROD_CTRL_ABORT_EN
  task automatic test_abort();
    obs_t o, e;
    logic ab;
    bus.abort = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if (bus.aborted !== 1'b0 || bus.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_in_idle aborted=%b busy=%b exp=0/0", bus.aborted, bus.busy);
    end
    bus.abort = 1'b0;
    bus.len   = N'(3);
    bus.start = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      o = sample();
      e = model(k, 3);
      cmp_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL abort_pre k=%0d got=%h exp=%h", k, o, e);
      end
      if (k == 0) bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.abort = 1'b0;
      o  = sample();
      ab = bus.aborted;
      cmp_cnt++;
      if (o !== obs_t'('0) || ab !== (k == 0)) begin
        err_cnt++;
        $display("FAIL abort_drain k=%0d got=%h aborted=%b exp=%h aborted=%b",
                 k, o, ab, obs_t'('0), (k == 0));
      end
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.len   = '0;
`ifdef DOT_PROD_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    test_lengths();
    test_async_reset();
    test_back_to_back();
`ifdef DOT_PROD_CTRL_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/dot_prod_ctrl.md
DOT_PROD_CTRL -- requirements
Module: dot_prod_ctrl

Interface
REQ-001 Parameter N, default 4: width of the vector length and element address.
REQ-002 Parameter PIPE_LAT, default 2, legal range 1..8: cycles from operand read-enable to product valid at the accumulator.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  begin a dot product; sampled only in IDLE.
REQ-007 len  input  N  element count; latched on the edge that accepts start.
REQ-008 rd_en  output  1  operand memory read strobe.
REQ-009 addr  output  N  operand element address.
REQ-010 acc_clr  output  1  one-cycle accumulator clear.
REQ-011 acc_en  output  1  accumulate the product arriving this cycle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 States SHALL be IDLE, CLR, RUN, DRAIN, DONE.
REQ-015 IDLE with start=1 SHALL latch len and go to CLR; start is ignored in all other states.
REQ-016 CLR SHALL last exactly one cycle with acc_clr=1, then go to RUN if len>0, else to DONE.
REQ-017 RUN SHALL assert rd_en for len consecutive cycles, with addr=0,1,...,len-1 in those cycles.
REQ-018 addr SHALL be produced by an internal N-bit counter; the maximum address is len-1 (at most 2^N-2), so the counter never wraps.
REQ-019 After the cycle with addr=len-1, the block SHALL go to DRAIN.
REQ-020 Each rd_en SHALL enter a PIPE_LAT-deep valid shift register; the register output drives acc_en, so acc_en follows each rd_en by exactly PIPE_LAT cycles.
REQ-021 DRAIN SHALL hold until the valid shift register is empty, then go to DONE.
REQ-022 DONE SHALL last one cycle with done=1, then go to IDLE; start in the DONE cycle is ignored.
REQ-023 If E0 is the edge that accepts start and len>0, done SHALL be high in the cycle after edge E(len+PIPE_LAT+1).
REQ-024 If len=0, done SHALL be high in the cycle after E1, and rd_en and acc_en SHALL never assert.
REQ-025 In IDLE, rd_en, acc_en, acc_clr and done SHALL be 0, and addr SHALL hold 0.
REQ-026 Changes on len while busy=1 SHALL have no effect.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, clear the address counter, clear the valid shift register and clear the latched len.
REQ-028 While in reset, all outputs SHALL be 0.
REQ-029 A reset asserted mid-operation SHALL abandon the operation without any done pulse.
REQ-030 The first start after reset deasserts SHALL be honoured on the first clock edge.

Configuration
REQ-031 Macro DOT_PROD_CTRL_ABORT_EN, when defined, SHALL add input abort (1 bit) and output aborted (1 bit).
REQ-032 With the macro defined, abort=1 in any non-IDLE state SHALL return the block to IDLE on the next edge and clear the valid shift register.
REQ-033 On such an abort, there SHALL be no done pulse, and aborted SHALL pulse for one cycle.
REQ-034 With the macro defined, abort SHALL be ignored in IDLE, and abort takes priority over start.
REQ-035 Without the macro, neither port SHALL exist, and behaviour SHALL be exactly REQ-014..REQ-030.

Verification (N=4, PIPE_LAT=2 unless noted)
REQ-036 Scenario: start with len=3 at E0 -> acc_clr after E0; rd_en after E1..E3 with addr 0,1,2; acc_en after E3..E5; done after E6 only; busy high from after E0 through after E6.
REQ-037 Scenario: start with len=0 -> acc_clr after E0, done after E1, no rd_en or acc_en, back in IDLE after E2.
REQ-038 Scenario: len=15 (maximum) -> 15 rd_en cycles with addr 0..14, no wrap, done after E18.
REQ-039 Scenario: rst pulsed asynchronously (between edges) during RUN with len=5 -> all outputs 0 immediately, no done; a following start with len=2 completes normally with done after E5.
REQ-040 Scenario: start held high continuously and len changed mid-run -> exactly one operation per IDLE visit, each using the len latched at acceptance.
REQ-041 Scenario (DOT_PROD_CTRL_ABORT_EN defined): abort asserted during DRAIN -> IDLE next cycle, aborted pulses once, no done, no further acc_en.
